// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - serial sequencer feeding the parity shift register
//
// Drives the shift-enable and serial-data inputs of the WIDTH-bit parity
// shift register. Two requesters share the register:
//   - a parallel word loader (load_valid/load_ready), serialized MSB first
//   - a manual single-bit shift from a raw, asynchronous button (man_req)
// The loader has priority. A manual request that cannot be serviced is
// reported on man_drop. word_done pulses once a full word has been shifted,
// so the downstream odd-parity counter/display can sample the register.
//
// Parameters:
//   WIDTH        shift register length / load word width
//   SHIFT_GAP    idle cycles between consecutive word shifts (0 = back-to-back)
//   SYNC_STAGES  flops in the man_req synchronizer (>= 2)
//
// Ports:
//   CLOCK_50    in   system clock, all logic on the rising edge
//   rst         in   synchronous reset, active-high
//   man_req     in   raw asynchronous manual-shift button level, active-high
//   man_bit     in   serial bit used by a manual shift (quasi-static switch)
//   load_valid  in   parallel load request
//   load_data   in   word to serialize, bit WIDTH-1 goes out first
//   load_ready  out  high only in IDLE and not in reset
//   shift_en    out  one-cycle shift strobe to the shift register
//   shift_bit   out  serial data, valid while shift_en is high
//   word_done   out  one-cycle pulse after the last bit of a loaded word
//   busy        out  sequencer is not IDLE
//   bits_left   out  bits of the current word not yet shifted
//   man_drop    out  one-cycle pulse when a manual request is discarded

module shift_seq_ctrl #(
    parameter int WIDTH       = 10,
    parameter int SHIFT_GAP   = 0,
    parameter int SYNC_STAGES = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         rst,
    input  logic                         man_req,
    input  logic                         man_bit,
    input  logic                         load_valid,
    input  logic [WIDTH-1:0]             load_data,
    output logic                         load_ready,
    output logic                         shift_en,
    output logic                         shift_bit,
    output logic                         word_done,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   bits_left,
    output logic                         man_drop
);

    localparam int BW = $clog2(WIDTH + 1);
    // One spare bit of headroom is not needed: the counter only ever holds
    // 1..SHIFT_GAP while in GAP.
    localparam int GW = (SHIFT_GAP > 1) ? $clog2(SHIFT_GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                  state;
    logic [WIDTH-1:0]        hold;
    logic [WIDTH-1:0]        hold_next;
    logic [GW-1:0]           gap_cnt;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    edge_q;
    logic                    man_evt;
    logic                    load_acc;

    // ------------------------------------------------------------------
    // Manual request: synchronize the raw button, then detect the rising
    // edge so a long press produces exactly one event. No debouncing is
    // done here; a bouncing contact yields one event per clean rise seen
    // after synchronization.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], man_req};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign man_evt = sync_q[SYNC_STAGES-1] & ~edge_q;

    // load_ready is gated by rst directly so nothing is accepted on the
    // same edge that resets the sequencer, and it rises as soon as rst drops.
    assign load_ready = (state == S_IDLE) && !rst;
    assign load_acc   = load_valid && load_ready;
    assign busy       = (state != S_IDLE);

    // Word after the bit currently on shift_bit has been consumed; its MSB
    // is the next bit to present.
    assign hold_next = hold << 1;

    // ------------------------------------------------------------------
    // Sequencer. shift_en/shift_bit/word_done/man_drop are registered:
    // each branch sets them for the cycle that follows the edge, so the
    // strobe is already valid in the first cycle of SHIFT.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state     <= S_IDLE;
            hold      <= '0;
            bits_left <= '0;
            gap_cnt   <= '0;
            shift_en  <= 1'b0;
            shift_bit <= 1'b0;
            word_done <= 1'b0;
            man_drop  <= 1'b0;
        end else begin
            shift_en  <= 1'b0;
            shift_bit <= 1'b0;
            word_done <= 1'b0;
            man_drop  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (load_acc) begin
                        hold      <= load_data;
                        bits_left <= BW'(WIDTH);
                        state     <= S_SHIFT;
                        shift_en  <= 1'b1;
                        shift_bit <= load_data[WIDTH-1];
                        // The loader wins a tie with a manual event.
                        man_drop  <= man_evt;
                    end else if (man_evt) begin
                        shift_en  <= 1'b1;
                        shift_bit <= man_bit;
                    end
                end

                S_SHIFT: begin
                    // The bit hold[WIDTH-1] is on the wire this cycle.
                    hold      <= hold_next;
                    bits_left <= bits_left - BW'(1);
                    man_drop  <= man_evt;
                    if (bits_left == BW'(1)) begin
                        state     <= S_DONE;
                        word_done <= 1'b1;
                    end else if (SHIFT_GAP == 0) begin
                        state     <= S_SHIFT;
                        shift_en  <= 1'b1;
                        shift_bit <= hold_next[WIDTH-1];
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= GW'(SHIFT_GAP);
                    end
                end

                S_GAP: begin
                    man_drop <= man_evt;
                    if (gap_cnt <= GW'(1)) begin
                        gap_cnt   <= '0;
                        state     <= S_SHIFT;
                        shift_en  <= 1'b1;
                        shift_bit <= hold[WIDTH-1];
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end

                S_DONE: begin
                    man_drop <= man_evt;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl

module tb_shift_seq_ctrl;

    localparam int W = 10;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic         rst;
    logic         man_req;
    logic         man_bit;
    logic         load_valid;
    logic [W-1:0] load_data;

    // index 0: SHIFT_GAP=0 instance, index 1: SHIFT_GAP=2 instance
    logic         lr [2];
    logic         se [2];
    logic         sb [2];
    logic         wd [2];
    logic         bz [2];
    logic         md [2];
    logic [3:0]   bl [2];

    shift_seq_ctrl #(.WIDTH(W), .SHIFT_GAP(0), .SYNC_STAGES(3)) u_dut0 (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .man_req    (man_req),
        .man_bit    (man_bit),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (lr[0]),
        .shift_en   (se[0]),
        .shift_bit  (sb[0]),
        .word_done  (wd[0]),
        .busy       (bz[0]),
        .bits_left  (bl[0]),
        .man_drop   (md[0])
    );

    shift_seq_ctrl #(.WIDTH(W), .SHIFT_GAP(2), .SYNC_STAGES(3)) u_dut2 (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .man_req    (man_req),
        .man_bit    (man_bit),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (lr[1]),
        .shift_en   (se[1]),
        .shift_bit  (sb[1]),
        .word_done  (wd[1]),
        .busy       (bz[1]),
        .bits_left  (bl[1]),
        .man_drop   (md[1])
    );

    typedef struct {
        int   c;
        logic b;
        int   bl;
    } sh_t;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] seq;   // seq[k] = k-th bit expected on shift_bit
        int           ones;
    } vec_t;

    sh_t  sh_q [2][$];
    int   dn_q [2][$];
    int   dr_q [2][$];
    sh_t  mon_e;
    int   mon_c;

    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    logic [W-1:0] sr [2];

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    // Cycle counter and a model of the downstream shift register.
    always @(posedge CLOCK_50) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++)
            if (se[i] === 1'b1) sr[i] <= {sr[i][W-2:0], sb[i]};
    end

    // Scoreboard: compare DUT pulses against queued expectations.
    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                while (sh_q[i].size() > 0 && sh_q[i][0].c < cyc) begin
                    mon_e = sh_q[i].pop_front();
                    chk($sformatf("missed_shift%0d", i), cyc, mon_e.c);
                end
                while (dn_q[i].size() > 0 && dn_q[i][0] < cyc) begin
                    mon_c = dn_q[i].pop_front();
                    chk($sformatf("missed_done%0d", i), cyc, mon_c);
                end
                while (dr_q[i].size() > 0 && dr_q[i][0] < cyc) begin
                    mon_c = dr_q[i].pop_front();
                    chk($sformatf("missed_drop%0d", i), cyc, mon_c);
                end

                if (se[i] !== 1'b0) begin
                    if (sh_q[i].size() == 0) begin
                        chk($sformatf("unexp_shift%0d", i), cyc, -1);
                    end else begin
                        mon_e = sh_q[i].pop_front();
                        chk($sformatf("shift_cyc%0d", i), cyc, mon_e.c);
                        chk($sformatf("shift_bit%0d", i), int'(sb[i]), int'(mon_e.b));
                        chk($sformatf("bits_left%0d", i), int'(bl[i]), mon_e.bl);
                    end
                end
                if (wd[i] !== 1'b0) begin
                    if (dn_q[i].size() == 0) begin
                        chk($sformatf("unexp_done%0d", i), cyc, -1);
                    end else begin
                        mon_c = dn_q[i].pop_front();
                        chk($sformatf("done_cyc%0d", i), cyc, mon_c);
                        chk($sformatf("done_ready%0d", i), int'(lr[i]), 0);
                        chk($sformatf("done_bits_left%0d", i), int'(bl[i]), 0);
                    end
                end
                if (md[i] !== 1'b0) begin
                    if (dr_q[i].size() == 0) begin
                        chk($sformatf("unexp_drop%0d", i), cyc, -1);
                    end else begin
                        mon_c = dr_q[i].pop_front();
                        chk($sformatf("drop_cyc%0d", i), cyc, mon_c);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] seq, input int acc);
        sh_t e;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < W; k++) begin
                e.c  = acc + k * (gap_of(i) + 1);
                e.b  = seq[k];
                e.bl = W - k;
                sh_q[i].push_back(e);
            end
            dn_q[i].push_back(acc + (W - 1) * (gap_of(i) + 1) + 1);
        end
    endtask

    task automatic start_word(input logic [W-1:0] d, input logic [W-1:0] seq);
        chk("ready0_pre", int'(lr[0]), 1);
        chk("ready2_pre", int'(lr[1]), 1);
        load_valid = 1'b1;
        load_data  = d;
        push_word(seq, cyc + 1);
        tick();
        load_valid = 1'b0;
        load_data  = W'($urandom);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready_low%0d", i), int'(lr[i]), 0);
            chk($sformatf("busy%0d", i), int'(bz[i]), 1);
            chk($sformatf("bits_left_start%0d", i), int'(bl[i]), W);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bz[0] !== 1'b0 || bz[1] !== 1'b0) && n < 200) begin
            tick();
            load_data = W'($urandom);
            n++;
        end
        chk("idle_timeout", int'(n < 200), 1);
    endtask

    task automatic run_word(input vec_t v);
        start_word(v.data, v.seq);
        wait_idle();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("sr_word%0d", i), int'(sr[i]), int'(v.data));
            chk($sformatf("sr_ones%0d", i), $countones(sr[i]), v.ones);
        end
    endtask

    task automatic man_press(input logic b, input int hold_cyc);
        sh_t e;
        man_bit = b;
        man_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e.c  = cyc + 4;
            e.b  = b;
            e.bl = 0;
            sh_q[i].push_back(e);
        end
        repeat (hold_cyc) tick();
        man_req = 1'b0;
        repeat (6) tick();
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{data: 10'b1011001110, seq: 10'b0111001101, ones: 6};
        vecs[1] = '{data: 10'h3FF,        seq: 10'h3FF,        ones: 10};
        vecs[2] = '{data: 10'h000,        seq: 10'h000,        ones: 0};
        vecs[3] = '{data: 10'b1000000001, seq: 10'b1000000001, ones: 2};
        vecs[4] = '{data: 10'b1100000000, seq: 10'b0000000011, ones: 2};
        vecs[5] = '{data: 10'b0101010101, seq: 10'b1010101010, ones: 5};

        rst        = 1'b1;
        man_req    = 1'b0;
        man_bit    = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;

        // Power-up reset.
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ready%0d", i), int'(lr[i]), 0);
            chk($sformatf("rst_busy%0d", i), int'(bz[i]), 0);
            chk($sformatf("rst_bits_left%0d", i), int'(bl[i]), 0);
            chk($sformatf("rst_pulses%0d", i), int'({se[i], wd[i], md[i]}), 0);
        end
        rst = 1'b0;
        #1;
        chk("rel_ready0", int'(lr[0]), 1);
        chk("rel_ready2", int'(lr[1]), 1);
        mon_en = 1'b1;
        tick();

        // Table of words, each run on both gap settings.
        for (int v = 0; v < 6; v++) begin
            run_word(vecs[v]);
            tick();
        end

        // Long manual press: a single shift per rise, both bit values.
        man_press(1'b1, 20);
        man_press(1'b0, 3);
        chk("man_sr0", int'(sr[0][1:0]), 2);
        chk("man_sr2", int'(sr[1][1:0]), 2);

        // Manual press during a word is dropped; the word is unaffected.
        start_word(vecs[0].data, vecs[0].seq);
        tick();
        tick();
        man_req = 1'b1;
        dr_q[0].push_back(cyc + 4);
        dr_q[1].push_back(cyc + 4);
        repeat (3) tick();
        man_req = 1'b0;
        wait_idle();
        chk("drop_word0", int'(sr[0]), int'(vecs[0].data));
        chk("drop_word2", int'(sr[1]), int'(vecs[0].data));
        repeat (6) tick();

        // Manual event on the same edge as a load accept: load wins.
        man_bit = 1'b1;
        man_req = 1'b1;
        repeat (3) tick();
        dr_q[0].push_back(cyc + 1);
        dr_q[1].push_back(cyc + 1);
        run_word(vecs[5]);
        man_req = 1'b0;
        repeat (6) tick();

        // Reset after four shifts of a word aborts it without word_done.
        start_word(vecs[0].data, vecs[0].seq);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            sh_q[i].delete();
            dn_q[i].delete();
            chk($sformatf("abort_busy%0d", i), int'(bz[i]), 0);
            chk($sformatf("abort_bits_left%0d", i), int'(bl[i]), 0);
            chk($sformatf("abort_ready%0d", i), int'(lr[i]), 0);
            chk($sformatf("abort_pulses%0d", i), int'({se[i], wd[i], md[i]}), 0);
        end
        tick();
        chk("abort_ready_hold0", int'(lr[0]), 0);
        rst = 1'b0;
        #1;
        chk("abort_rel_ready0", int'(lr[0]), 1);
        chk("abort_rel_ready2", int'(lr[1]), 1);
        chk("abort_partial0", int'(sr[0][3:0]), 4'b1011);
        chk("abort_partial2", int'(sr[1][1:0]), 2'b10);
        tick();
        run_word(vecs[1]);
        repeat (4) tick();

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("left_shift%0d", i), sh_q[i].size(), 0);
            chk($sformatf("left_done%0d", i), dn_q[i].size(), 0);
            chk($sformatf("left_drop%0d", i), dr_q[i].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

endmodule
